// File: rtl/counter_seq_arb.sv
// ============================================================================
// Module   : counter_seq_arb
// Purpose  : Round-robin sharing of one loadable up/down counter among
//            NUM_REQ requesters; build with COUNTER_SEQ_ABORT_EN for abort.
// Revision : 1.0
// ============================================================================
`default_nettype none

module counter_seq_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int STEP_W  = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*WIDTH-1:0]  i_req_val,
  input  logic [NUM_REQ-1:0]        i_req_mode,
  input  logic [NUM_REQ*STEP_W-1:0] i_req_steps,
`ifdef COUNTER_SEQ_ABORT_EN
  input  logic                      i_abort,
  output logic                      o_rsp_aborted,
`endif
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_busy,
  output logic                      o_rsp_valid,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic [WIDTH-1:0]          o_rsp_data,
  output logic [WIDTH-1:0]          o_cnt_data_in,
  output logic                      o_cnt_load,
  output logic                      o_cnt_mode,
  input  logic [WIDTH-1:0]          i_cnt_data_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RUN     = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [WIDTH-1:0]    r_val;
  logic                r_mode;
  logic [STEP_W-1:0]   r_steps;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [WIDTH-1:0]    r_rsp_data;
  logic                w_found;
  logic [ID_W-1:0]     w_win;
  logic                w_abort;

`ifdef COUNTER_SEQ_ABORT_EN
  logic r_abort_hit;
  logic r_rsp_aborted;

  assign w_abort       = i_abort;
  assign o_rsp_aborted = r_rsp_aborted;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_abort_hit   <= 1'b0;
      r_rsp_aborted <= 1'b0;
    end else begin
      if (r_state == S_LOAD) r_abort_hit <= 1'b0;
      else if (r_state == S_RUN) r_abort_hit <= i_abort;
      if (r_state == S_CAPTURE) r_rsp_aborted <= r_abort_hit;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  // Search begins one past the last winner and wraps, giving round-robin order.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && i_req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_next = S_LOAD;
      S_LOAD:    w_next = (r_steps == '0) ? S_CAPTURE : S_RUN;
      S_RUN:     if (r_steps == STEP_W'(1) || w_abort) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_id        <= '0;
      r_val       <= '0;
      r_mode      <= 1'b0;
      r_steps     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ptr   <= w_win;
            r_id    <= w_win;
            r_val   <= i_req_val[int'(w_win)*WIDTH +: WIDTH];
            r_mode  <= i_req_mode[w_win];
            r_steps <= i_req_steps[int'(w_win)*STEP_W +: STEP_W];
          end
        end
        S_RUN: r_steps <= r_steps - STEP_W'(1);
        S_CAPTURE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          r_rsp_data  <= i_cnt_data_out;
        end
        default: ;
      endcase
    end
  end

  // All outputs decode from registered state only.
  always_comb begin
    o_gnt         = '0;
    o_cnt_load    = 1'b0;
    o_cnt_mode    = 1'b0;
    o_cnt_data_in = '0;
    case (r_state)
      S_LOAD: begin
        o_gnt[r_id]   = 1'b1;
        o_cnt_load    = 1'b1;
        o_cnt_mode    = r_mode;
        o_cnt_data_in = r_val;
      end
      S_RUN:   o_cnt_mode = r_mode;
      default: ;
    endcase
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_counter_seq_arb.sv
// ============================================================================
// Module   : tb_counter_seq_arb
// Purpose  : Directed self-checking bench for counter_seq_arb with a counter model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_counter_seq_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] req_val = '0;
  logic [3:0]  req_mode = '0;
  logic [31:0] req_steps = '0;
  logic [3:0]  gnt;
  logic        busy;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic [3:0]  cnt_din;
  logic        cnt_load;
  logic        cnt_mode;
  logic [3:0]  cnt_q = '0;
`ifdef COUNTER_SEQ_ABORT_EN
  logic        abort = 1'b0;
  logic        rsp_aborted;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (cnt_load)      cnt_q <= cnt_din;
    else if (cnt_mode) cnt_q <= cnt_q + 4'd1;
    else               cnt_q <= cnt_q - 4'd1;
  end

  counter_seq_arb #(.NUM_REQ(4), .WIDTH(4), .STEP_W(8)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .i_req_val      (req_val),
    .i_req_mode     (req_mode),
    .i_req_steps    (req_steps),
`ifdef COUNTER_SEQ_ABORT_EN
    .i_abort        (abort),
    .o_rsp_aborted  (rsp_aborted),
`endif
    .o_gnt          (gnt),
    .o_busy         (busy),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_id       (rsp_id),
    .o_rsp_data     (rsp_data),
    .o_cnt_data_in  (cnt_din),
    .o_cnt_load     (cnt_load),
    .o_cnt_mode     (cnt_mode),
    .i_cnt_data_out (cnt_q)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if ({busy, gnt, cnt_load, cnt_mode, cnt_din} !== 11'd0) begin errors++;
      $display("FAIL reset_ctrl: got busy=%b gnt=%b load=%b mode=%b din=%h want all 0", busy, gnt, cnt_load, cnt_mode, cnt_din); end
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== 7'd0) begin errors++;
      $display("FAIL reset_rsp: got v=%b id=%0d data=%h want 0", rsp_valid, rsp_id, rsp_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_up();
    req = 4'b0001; req_val[3:0] = 4'hE; req_mode[0] = 1'b1; req_steps[7:0] = 8'd3;
    step();
    checks++; if ({gnt, cnt_load, cnt_mode, cnt_din} !== {4'b0001, 1'b1, 1'b1, 4'hE}) begin errors++;
      $display("FAIL up_load: got gnt=%b load=%b mode=%b din=%h want 0001 1 1 e", gnt, cnt_load, cnt_mode, cnt_din); end
    req = '0; req_val[3:0] = 4'h5; req_mode[0] = 1'b0; req_steps[7:0] = 8'd9;
    for (int i = 1; i <= 4; i++) step();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL up_early: got rsp_valid=%b busy=%b want 0 1", rsp_valid, busy); end
    step();
    checks++; if ({rsp_valid, rsp_id, rsp_data, busy} !== {1'b1, 2'd0, 4'h1, 1'b0}) begin errors++;
      $display("FAIL up_rsp: got v=%b id=%0d data=%h busy=%b want 1 0 1 0", rsp_valid, rsp_id, rsp_data, busy); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++;
      $display("FAIL up_rsp_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_zero_steps();
    req = 4'b0100; req_val[11:8] = 4'h7; req_mode[2] = 1'b0; req_steps[23:16] = 8'd0;
    step();
    checks++; if ({gnt, cnt_load, cnt_din} !== {4'b0100, 1'b1, 4'h7}) begin errors++;
      $display("FAIL zero_load: got gnt=%b load=%b din=%h want 0100 1 7", gnt, cnt_load, cnt_din); end
    req = '0;
    step();
    checks++; if ({cnt_load, busy, rsp_valid} !== 3'b010) begin errors++;
      $display("FAIL zero_capture: got load=%b busy=%b v=%b want 0 1 0", cnt_load, busy, rsp_valid); end
    step();
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 4'h7}) begin errors++;
      $display("FAIL zero_rsp: got v=%b id=%0d data=%h want 1 2 7", rsp_valid, rsp_id, rsp_data); end
  endtask

  task automatic test_round_robin();
    int cyc = 0;
    int last_cyc = 0;
    int last_g = 0;
    test_reset();
    for (int i = 0; i < 4; i++) begin
      req_val[i*4 +: 4]   = 4'(i + 1);
      req_mode[i]         = 1'b1;
      req_steps[i*8 +: 8] = 8'd1;
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int waited = 0;
      step(); cyc++;
      while (gnt === 4'b0000 && waited < 10) begin
        if (rsp_valid === 1'b1) begin
          checks++; if (rsp_id !== 2'(last_g) || rsp_data !== 4'(last_g + 2)) begin errors++;
            $display("FAIL rr_rsp: got id=%0d data=%h want %0d %h", rsp_id, rsp_data, last_g, 4'(last_g + 2)); end
        end
        step(); cyc++; waited++;
      end
      checks++; if (gnt !== 4'(1 << (n % 4))) begin errors++;
        $display("FAIL rr_gnt%0d: got %b want %b (waited %0d)", n, gnt, 4'(1 << (n % 4)), waited); end
      if (n > 0) begin
        checks++; if (cyc - last_cyc != 4) begin errors++;
          $display("FAIL rr_spacing%0d: got %0d want 4", n, cyc - last_cyc); end
      end
      last_cyc = cyc;
      last_g = n % 4;
    end
    req = '0;
    for (int i = 0; i < 3; i++) step();
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 4'h2}) begin errors++;
      $display("FAIL rr_last_rsp: got v=%b id=%0d data=%h want 1 0 2", rsp_valid, rsp_id, rsp_data); end
  endtask

  task automatic test_down_long();
    int busy_cnt = 0;
    req = 4'b0010; req_val[7:4] = 4'h2; req_mode[1] = 1'b0; req_steps[15:8] = 8'd20;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++;
      $display("FAIL down_gnt: got %b want 0010", gnt); end
    req = '0;
    while (busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      step();
    end
    checks++; if (busy_cnt != 22) begin errors++;
      $display("FAIL down_busy_len: got %0d want 22", busy_cnt); end
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 4'hE}) begin errors++;
      $display("FAIL down_rsp: got v=%b id=%0d data=%h want 1 1 e", rsp_valid, rsp_id, rsp_data); end
  endtask

  task automatic test_reset_mid_run();
    int spurious = 0;
    req = 4'b0100; req_val[11:8] = 4'h5; req_mode[2] = 1'b1; req_steps[23:16] = 8'd10;
    step();
    checks++; if (gnt !== 4'b0100) begin errors++;
      $display("FAIL mid_gnt: got %b want 0100", gnt); end
    req = '0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, gnt, cnt_load, rsp_valid} !== 7'd0) begin errors++;
      $display("FAIL mid_async_reset: got busy=%b gnt=%b load=%b v=%b want all 0", busy, gnt, cnt_load, rsp_valid); end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid === 1'b1 || gnt !== 4'b0000) spurious++;
    end
    checks++; if (spurious != 0) begin errors++;
      $display("FAIL mid_no_rsp: got %0d spurious cycles want 0", spurious); end
    req = 4'b1001; req_steps[7:0] = 8'd0; req_steps[31:24] = 8'd0; req_val[3:0] = 4'h9;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++;
      $display("FAIL mid_ptr_reset: got %b want 0001", gnt); end
    req = '0;
    step();
    step();
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 4'h9}) begin errors++;
      $display("FAIL mid_after_rsp: got v=%b id=%0d data=%h want 1 0 9", rsp_valid, rsp_id, rsp_data); end
  endtask

`ifdef COUNTER_SEQ_ABORT_EN
  task automatic test_abort();
    req = 4'b0001; req_val[3:0] = 4'h0; req_mode[0] = 1'b1; req_steps[7:0] = 8'd10;
    step();
    req = '0;
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL abort_capture: got busy=%b v=%b want 1 0", busy, rsp_valid); end
    step();
    checks++; if ({rsp_valid, rsp_data, rsp_aborted} !== {1'b1, 4'h3, 1'b1}) begin errors++;
      $display("FAIL abort_rsp: got v=%b data=%h aborted=%b want 1 3 1", rsp_valid, rsp_data, rsp_aborted); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_up();
    test_zero_steps();
    test_round_robin();
    test_down_long();
    test_reset_mid_run();
`ifdef COUNTER_SEQ_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_seq_arb.md
Name: counter_seq_arb

Overview:
- Shares one WIDTH-bit loadable up/down counter between NUM_REQ requesters.
- Arbitrates requests round-robin, then sequences the counter: load a start value, count STEPS cycles in the requested direction, capture the result, and return it to the winning requester.
- Sits between requester agents and the counter's data_in/load/mode/data_out pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, counter data width
- STEP_W, 8, width of the step-count field

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester request; held high until gnt seen
- req_val  input  NUM_REQ*WIDTH  per-requester start value, slice i = requester i
- req_mode  input  NUM_REQ  per-requester direction, 1 = up, 0 = down
- req_steps  input  NUM_REQ*STEP_W  per-requester count length
- gnt  output  NUM_REQ  one-hot grant pulse, 1 cycle
- busy  output  1  high in every state except IDLE
- rsp_valid  output  1  one-cycle result strobe
- rsp_id  output  $clog2(NUM_REQ)  index of the requester the result belongs to
- rsp_data  output  WIDTH  captured counter value
- cnt_data_in  output  WIDTH  to counter data_in
- cnt_load  output  1  to counter load
- cnt_mode  output  1  to counter mode
- cnt_data_out  input  WIDTH  from counter data_out (registered in the counter)

Behaviour:
- Counter contract: each clock edge, load=1 gives q<=data_in; otherwise mode=1 gives q+1, mode=0 gives q-1, modulo 2^WIDTH. The counter has no hold state.
- FSM states: IDLE, LOAD, RUN, CAPTURE.
- IDLE:
  - With no req, stay in IDLE.
  - With any req, choose the round-robin winner, latch its val/mode/steps/id, and go to LOAD.
- LOAD:
  - gnt[id]=1, cnt_load=1, cnt_data_in=latched val, cnt_mode=latched mode.
  - steps==0 goes to CAPTURE; otherwise load step counter with steps and go to RUN.
- RUN:
  - cnt_load=0, cnt_mode=latched mode.
  - Decrement step counter each cycle; at 1, go to CAPTURE. RUN lasts exactly steps cycles.
- CAPTURE:
  - cnt_load=0.
  - Register rsp_data<=cnt_data_out and rsp_id<=id, set rsp_valid for the next cycle, and go to IDLE.
- Result value: rsp_data = (val + steps) mod 2^WIDTH for up, (val - steps) mod 2^WIDTH for down.
- Latency: gnt in cycle G, rsp_valid in cycle G+steps+2. rsp_valid coincides with IDLE, so back-to-back arbitration is allowed.
- Round-robin:
  - Pointer = last granted index.
  - Search starts at pointer+1 and wraps to 0.
  - Reset pointer = NUM_REQ-1, so req[0] wins first.
  - Pointer updates only on grant.
- No combinational path from req* to any output. All outputs are decoded from registers only.
- req deasserting while not granted: request is withdrawn, with no side effects.
- req fields are sampled only on the IDLE to LOAD edge. Later changes are ignored.
- Outputs in IDLE: cnt_load=0, cnt_mode=0, cnt_data_in=0, gnt=0.
- Reset (asynchronous, any state):
  - State returns to IDLE; all outputs go to 0, including rsp_valid, rsp_id and rsp_data.
  - Pointer returns to NUM_REQ-1. An in-flight operation is dropped with no rsp.
- gnt is exactly one-hot or zero. rsp_valid never asserts without a preceding gnt.

Optional Feature:
- Macro: COUNTER_SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output rsp_aborted (1 bit, valid with rsp_valid, reset 0).
  - abort=1 during RUN forces CAPTURE on the next edge. The partial count is captured and rsp_aborted=1.
  - abort is ignored in IDLE, LOAD and CAPTURE.
- Undefined: abort and rsp_aborted do not exist, and RUN always completes.

Test Plan:
- Single up request: req[0], val=4'hE, mode=1, steps=3 -> gnt[0] in cycle G; rsp_valid in G+5 with rsp_id=0, rsp_data=4'h1 (wrap).
- Zero steps: req[2], val=4'h7, mode=0, steps=0 -> cnt_load 1 cycle; rsp_valid in G+2 with rsp_data=4'h7, no RUN cycles.
- Round-robin fairness: req[3:0]=4'b1111 held, each with steps=1 -> grant order 0,1,2,3,0; exactly one gnt bit per grant; gnt spacing 4 cycles (rsp cycle reused for the next arbitration).
- Down wrap with long count: req[1], val=4'h2, mode=0, steps=8'd20 -> rsp_data=4'hE, rsp_id=1, busy high for 22 cycles.
- Reset mid-RUN: start steps=10 and assert reset low in RUN cycle 4 -> busy, gnt, cnt_load and rsp_valid go to 0 immediately; no rsp after release; next grant goes to req[0] first.
- With COUNTER_SEQ_ABORT_EN: val=4'h0, up, steps=10, abort in RUN cycle 3 -> rsp_data=4'h3, rsp_aborted=1.
